// File: rtl/branch_predict_resolve.sv
// EX-stage resolver for the six RV64I conditional branches, with a direct-mapped
// 2-bit BHT feeding IF, a registered flush pulse and saturating statistics.
module branch_predict_resolve #(
    parameter int XLEN      = 64,
    parameter int PC_W      = 64,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             sel,
    output logic             mispredict,
    output logic             bad_funct3,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic logic [1:0] sat2_next(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
        end else begin
            nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
        end
        return nxt;
    endfunction

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_d [BHT_DEPTH];
    logic             mispredict_q, mispredict_d;
    logic             bad_funct3_q, bad_funct3_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] if_idx_s;
    logic [IDX_W-1:0] ex_idx_s;
    logic             eq_s, lt_s_s, lt_u_s;
    logic             supported_s, cond_s, resolve_s, sel_s;
    logic             unused_pc_s;

    assign if_idx_s    = if_pc[IDX_W+1:2];
    assign ex_idx_s    = ex_pc[IDX_W+1:2];
    assign unused_pc_s = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    assign eq_s   = (a == b);
    assign lt_s_s = ($signed(a) < $signed(b));
    assign lt_u_s = (a < b);

    // Branch condition decode; 010/011 are the unsupported encodings.
    always_comb begin
        supported_s = 1'b1;
        cond_s      = 1'b0;
        case (funct3)
            3'b000:  cond_s = eq_s;
            3'b001:  cond_s = ~eq_s;
            3'b100:  cond_s = lt_s_s;
            3'b101:  cond_s = ~lt_s_s;
            3'b110:  cond_s = lt_u_s;
            3'b111:  cond_s = ~lt_u_s;
            default: supported_s = 1'b0;
        endcase
    end

    assign resolve_s = ex_valid & branch & supported_s;
    assign sel_s     = resolve_s & cond_s;

    // Next-state for BHT, flush/bad pulses and saturating counters.
    always_comb begin
        bht_d = bht_q;
        if (resolve_s) begin
            bht_d[ex_idx_s] = sat2_next(bht_q[ex_idx_s], sel_s);
        end else begin
            bht_d = bht_q;
        end

        mispredict_d = resolve_s & (sel_s ^ ex_pred_taken);
        bad_funct3_d = ex_valid & branch & (funct3[2:1] == 2'b01);

        if (resolve_s && (branch_count_q != {CNT_W{1'b1}})) begin
            branch_count_d = branch_count_q + CNT_W'(1);
        end else begin
            branch_count_d = branch_count_q;
        end

        if (mispredict_d && (mispredict_count_q != {CNT_W{1'b1}})) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end else begin
            mispredict_count_d = mispredict_count_q;
        end
    end

    // State registers; reset leaves every BHT entry weakly not-taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
            mispredict_q       <= 1'b0;
            bad_funct3_q       <= 1'b0;
            branch_count_q     <= {CNT_W{1'b0}};
            mispredict_count_q <= {CNT_W{1'b0}};
        end else begin
            bht_q              <= bht_d;
            mispredict_q       <= mispredict_d;
            bad_funct3_q       <= bad_funct3_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Prediction reads the pre-update entry even when IF and EX hit the same index.
    assign if_pred_taken    = bht_q[if_idx_s][1];
    assign sel              = sel_s;
    assign mispredict       = mispredict_q;
    assign bad_funct3       = bad_funct3_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: compares, BHT training, collision,
// unsupported funct3, mid-stream reset and counter saturation (CNT_W=4).
module tb_branch_predict_resolve;

    localparam int XLEN  = 64;
    localparam int PC_W  = 64;
    localparam int DEPTH = 256;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic            branch;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [PC_W-1:0] ex_pc;
    logic            ex_pred_taken;
    logic            sel;
    logic            mispredict;
    logic            bad_funct3;
    logic [CW-1:0]   branch_count;
    logic [CW-1:0]   mispredict_count;

    int total_cnt = 0;
    int bad_cnt   = 0;

    branch_predict_resolve #(
        .XLEN(XLEN), .PC_W(PC_W), .BHT_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .branch(branch), .funct3(funct3), .a(a), .b(b),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .sel(sel),
        .mispredict(mispredict), .bad_funct3(bad_funct3),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        branch        = 1'b0;
        funct3        = 3'b000;
        a             = 64'd0;
        b             = 64'd0;
        ex_pc         = 64'd0;
        ex_pred_taken = 1'b0;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] pc, input logic pred);
        ex_valid      = 1'b1;
        branch        = 1'b1;
        funct3        = f3;
        a             = av;
        b             = bv;
        ex_pc         = pc;
        ex_pred_taken = pred;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        if_pc = 64'h40;
        reset = 1'b1;
        repeat (2) step();
        chk("rst_mp", {63'd0, mispredict}, 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_pred", {63'd0, if_pred_taken}, 64'd0);
        chk("rst_bc", {60'd0, branch_count}, 64'd0);
        chk("rst_mc", {60'd0, mispredict_count}, 64'd0);
        chk("rst_bad", {63'd0, bad_funct3}, 64'd0);

        // Compare set, each vector held for one cycle at an unrelated PC.
        step();
        drive(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h300, 1'b0); #1; chk("blt", {63'd0, sel}, 64'd1);
        step();
        drive(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h300, 1'b0); #1; chk("bltu", {63'd0, sel}, 64'd0);
        step();
        drive(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h300, 1'b0); #1; chk("bge", {63'd0, sel}, 64'd0);
        step();
        drive(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h300, 1'b0); #1; chk("bgeu", {63'd0, sel}, 64'd1);
        step();
        drive(3'b000, 64'd5, 64'd5, 64'h300, 1'b0); #1; chk("beq", {63'd0, sel}, 64'd1);
        step();
        drive(3'b001, 64'd5, 64'd5, 64'h300, 1'b0); #1; chk("bne", {63'd0, sel}, 64'd0);
        step();
        drive(3'b000, 64'd5, 64'd5, 64'h300, 1'b0); ex_valid = 1'b0; #1; chk("sel_novalid", {63'd0, sel}, 64'd0);
        ex_valid = 1'b1; branch = 1'b0; #1; chk("sel_nobranch", {63'd0, sel}, 64'd0);
        idle();
        step();

        // Fresh start before training.
        reset = 1'b1; #2; reset = 1'b0;
        chk("rst2_bc", {60'd0, branch_count}, 64'd0);

        // Training at 0x100: three taken beq, each predicted not-taken.
        if_pc = 64'h100;
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 64'd7, 64'd7, 64'h100, 1'b0);
            step();
            chk($sformatf("train_mp%0d", i), {63'd0, mispredict}, 64'd1);
        end
        idle();
        chk("train_pred", {63'd0, if_pred_taken}, 64'd1);
        chk("train_bc", {60'd0, branch_count}, 64'd3);
        chk("train_mc", {60'd0, mispredict_count}, 64'd3);
        step();
        chk("train_mp_end", {63'd0, mispredict}, 64'd0);

        // One not-taken from 11 leaves 10, still predicting taken.
        drive(3'b000, 64'd7, 64'd8, 64'h100, 1'b1);
        step();
        idle();
        chk("nt_mp", {63'd0, mispredict}, 64'd1);
        chk("nt_pred", {63'd0, if_pred_taken}, 64'd1);
        chk("nt_mc", {60'd0, mispredict_count}, 64'd4);

        // Same-cycle collision at 0x200: old value visible until the edge.
        if_pc = 64'h200;
        drive(3'b000, 64'd1, 64'd1, 64'h200, 1'b0);
        #1;
        chk("coll_same", {63'd0, if_pred_taken}, 64'd0);
        step();
        idle();
        chk("coll_next", {63'd0, if_pred_taken}, 64'd1);
        chk("coll_bc", {60'd0, branch_count}, 64'd5);

        // Unsupported funct3 at 0x300 (entry still 01).
        if_pc = 64'h300;
        step();
        drive(3'b011, 64'd1, 64'd1, 64'h300, 1'b0);
        #1;
        chk("bad_sel", {63'd0, sel}, 64'd0);
        step();
        idle();
        chk("bad_pulse", {63'd0, bad_funct3}, 64'd1);
        chk("bad_mp", {63'd0, mispredict}, 64'd0);
        chk("bad_bc", {60'd0, branch_count}, 64'd5);
        chk("bad_mc", {60'd0, mispredict_count}, 64'd5);
        chk("bad_pred", {63'd0, if_pred_taken}, 64'd0);
        step();
        chk("bad_end", {63'd0, bad_funct3}, 64'd0);

        // Reset while a mispredicting branch sits in EX.
        if_pc = 64'h100;
        drive(3'b000, 64'd3, 64'd3, 64'h100, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_bc_async", {60'd0, branch_count}, 64'd0);
        step();
        idle();
        #1;
        reset = 1'b0;
        step();
        chk("mid_mp", {63'd0, mispredict}, 64'd0);
        chk("mid_mc", {60'd0, mispredict_count}, 64'd0);
        chk("mid_bc", {60'd0, branch_count}, 64'd0);
        chk("mid_pred100", {63'd0, if_pred_taken}, 64'd0);
        if_pc = 64'h200;
        #1;
        chk("mid_pred200", {63'd0, if_pred_taken}, 64'd0);

        // Saturation: 17 correctly predicted branches on a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            drive(3'b000, 64'd2, 64'd2, 64'h300, 1'b1);
            step();
        end
        chk("sat_bc", {60'd0, branch_count}, 64'd15);
        chk("sat_mc", {60'd0, mispredict_count}, 64'd0);
        step();
        idle();
        chk("sat_hold", {60'd0, branch_count}, 64'd15);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised successor to the EX-stage branch-select logic of the pipelined core.
- Resolves all six RV64I conditional branches with signed/unsigned compares at XLEN width.
- Holds a direct-mapped branch history table (BHT) of 2-bit saturating counters that gives IF a taken prediction.
- Registers a one-cycle mispredict/flush pulse and keeps saturating branch and mispredict statistics.

Parameters:
- XLEN, 64, operand width for comparisons.
- PC_W, 64, program counter width.
- BHT_DEPTH, 64, number of BHT entries; must be a power of two, at least 2.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- if_pc  input  PC_W  PC of the instruction being fetched.
- if_pred_taken  output  1  combinational BHT prediction for if_pc.
- ex_valid  input  1  EX stage holds a valid instruction.
- branch  input  1  EX instruction is a conditional branch.
- funct3  input  3  branch type.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- ex_pc  input  PC_W  PC of the EX instruction.
- ex_pred_taken  input  1  prediction carried down the pipe with the EX instruction.
- sel  output  1  combinational actual-taken result.
- mispredict  output  1  registered one-cycle flush pulse.
- bad_funct3  output  1  registered one-cycle pulse for an unsupported funct3.
- branch_count  output  CNT_W  resolved branches, saturating.
- mispredict_count  output  CNT_W  mispredictions, saturating.

Behaviour:
- funct3 encoding (RISC-V standard):
  - 000 beq: a==b.
  - 001 bne: a!=b.
  - 100 blt: signed a<b.
  - 101 bge: signed a>=b.
  - 110 bltu: unsigned a<b.
  - 111 bgeu: unsigned a>=b.
- Resolve condition: resolve = ex_valid & branch & funct3 is one of the six supported codes.
- sel:
  - sel = resolve & condition, purely combinational.
  - sel is 0 whenever branch=0, ex_valid=0 or funct3 is unsupported.
  - No latch and no held value.
- BHT indexing: index = pc[log2(BHT_DEPTH)+1 : 2], i.e. word-aligned PC bits.
  - if_pred_taken = BHT[if_index][1], combinational.
- BHT update at posedge when resolve=1:
  - If sel=1, increment the counter, saturating at 11.
  - Otherwise decrement, saturating at 00.
  - No update when resolve=0.
- BHT read/write collision: if_index equal to ex_index in the same cycle returns the pre-update value. No bypass.
- mispredict:
  - At posedge, mispredict <= resolve & (sel != ex_pred_taken).
  - It is high for exactly one cycle, the cycle after EX.
  - The pipeline uses it to flush IF/ID and redirect.
- bad_funct3:
  - At posedge, bad_funct3 <= ex_valid & branch & funct3 in {010, 011}.
  - Sets sel=0, no BHT update, no counter change.
- Counters:
  - branch_count increments when resolve=1.
  - mispredict_count increments when resolve=1 and a mispredict occurs (same condition as the registered pulse).
  - Both hold at all-ones and never wrap.
- Reset (asynchronous, effective immediately, including mid-operation):
  - Every BHT entry set to 01 (weakly not-taken).
  - mispredict=0, bad_funct3=0, branch_count=0, mispredict_count=0.
  - A resolution in flight during reset is discarded; there is no pulse after release.
- Back-to-back branches on consecutive cycles each update and each may pulse mispredict. There are no bubbles.

Test Plan:
- Reset, then drive if_pc=0x40 -> if_pred_taken=0; all counters 0; mispredict=0.
- Compare set with a=0xFFFF_FFFF_FFFF_FFFF, b=1, ex_valid=1, branch=1:
  - blt -> sel=1; bltu -> sel=0; bge -> sel=0; bgeu -> sel=1.
  - beq with a=b=5 -> sel=1; bne with a=b=5 -> sel=0.
- Training: ex_pc=0x100, beq taken with ex_pred_taken=0, three consecutive cycles:
  - mispredict pulses on cycles 2, 3 and 4.
  - BHT[0x100] becomes 11; if_pc=0x100 -> if_pred_taken=1.
  - branch_count=3, mispredict_count=3.
- Same-cycle collision: if_pc=ex_pc=0x200, entry at 01, taken branch -> if_pred_taken=0 that cycle, 1 the next cycle.
- Unsupported funct3=011 with branch=1 -> sel=0; bad_funct3 pulses 1 cycle; BHT and counters unchanged.
- Assert reset mid-stream with a mispredicting branch in EX -> mispredict=0 after release; counters 0; BHT entries 01.
- Counter saturation with CNT_W=4: 17 resolved branches -> branch_count=15 and stays there.
